// File: rtl/apb_lockstep_checker.sv
// N-way lockstep checker for replicated APB completers: merges replica responses,
// tolerates PREADY skew up to MAX_SKEW cycles, and flags/counts/localises divergence.
module apb_lockstep_checker #(
  parameter int NUM_DUTS   = 2,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_SKEW   = 4,
  parameter int CNT_WIDTH  = 16,
  localparam int IDX_W     = (NUM_DUTS > 1) ? $clog2(NUM_DUTS) : 1
) (
  input  logic                           PCLK,
  input  logic                           PRESETn,
  input  logic                           PSEL,
  input  logic                           PENABLE,
  input  logic                           PWRITE,
  input  logic [NUM_DUTS-1:0]            dut_pready,
  input  logic [NUM_DUTS*DATA_WIDTH-1:0] dut_prdata,
  input  logic [NUM_DUTS-1:0]            dut_pslverr,
  input  logic                           clear,
  output logic                           pready_out,
  output logic [DATA_WIDTH-1:0]          prdata_out,
  output logic                           pslverr_out,
  output logic                           mismatch,
  output logic [NUM_DUTS-1:0]            mismatch_mask,
  output logic                           mismatch_sticky,
  output logic [CNT_WIDTH-1:0]           mismatch_count,
  output logic                           timeout,
  output logic                           protocol_err,
  output logic [IDX_W-1:0]               first_idx
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_COMPARE} state_t;

  localparam logic [3:0] SKEW_LIM = 4'(MAX_SKEW);

  state_t                state_q, state_d;
  logic [NUM_DUTS-1:0]   cap_q, cap_d, new_cap, cap_n;
  logic [DATA_WIDTH-1:0] data_q [NUM_DUTS];
  logic [DATA_WIDTH-1:0] data_n [NUM_DUTS];
  logic [NUM_DUTS-1:0]   err_q, err_n;
  logic [3:0]            skew_q, skew_d, skew_inc;

  logic                  access, capturing, all_cap;
  logic                  go_cmp, tmo, abort;

  logic [DATA_WIDTH-1:0] ref_data;
  logic                  ref_err;
  logic [NUM_DUTS-1:0]   mask_n;
  logic [IDX_W-1:0]      fail_idx;

  logic                  pready_q, pready_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  pslverr_q, pslverr_d;
  logic                  mismatch_q, mismatch_d;
  logic [NUM_DUTS-1:0]   mask_q, mask_d;
  logic                  sticky_q, sticky_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  timeout_q, timeout_d;
  logic                  perr_q, perr_d;
  logic [IDX_W-1:0]      first_q, first_d;

  assign access    = PSEL & PENABLE;
  assign capturing = access && (state_q != S_COMPARE);
  assign new_cap   = capturing ? (dut_pready & ~cap_q) : '0;
  assign cap_n     = cap_q | new_cap;
  assign all_cap   = &cap_n;
  assign skew_inc  = skew_q + 4'd1;

  // Each replica latches its response once per transfer; later PREADY pulses are ignored.
  always_comb begin
    for (int i = 0; i < NUM_DUTS; i++) begin
      data_n[i] = data_q[i];
      err_n[i]  = err_q[i];
      if (new_cap[i]) begin
        data_n[i] = dut_prdata[i*DATA_WIDTH +: DATA_WIDTH];
        err_n[i]  = dut_pslverr[i];
      end
    end
  end

  // Next-state and transition flags.
  always_comb begin
    state_d = state_q;
    go_cmp  = 1'b0;
    tmo     = 1'b0;
    abort   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access) begin
          if (all_cap) begin
            state_d = S_COMPARE;
            go_cmp  = 1'b1;
          end else begin
            state_d = S_COLLECT;
          end
        end
      end
      S_COLLECT: begin
        if (!access) begin
          abort   = 1'b1;
          state_d = S_IDLE;
        end else if (all_cap) begin
          go_cmp  = 1'b1;
          state_d = S_COMPARE;
        end else if ((cap_q != '0) && (skew_inc == SKEW_LIM)) begin
          tmo     = 1'b1;
          go_cmp  = 1'b1;
          state_d = S_COMPARE;
        end
      end
      S_COMPARE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Skew counts edges since the first capture; it only runs once something has been caught.
  assign skew_d = ((state_d == S_COLLECT) && (cap_q != '0)) ? skew_inc : 4'd0;
  assign cap_d  = (state_d == S_COLLECT) ? cap_n : '0;

  // Reference is the lowest-index captured replica; missing replicas always fail.
  always_comb begin
    ref_data = '0;
    ref_err  = 1'b0;
    for (int i = NUM_DUTS - 1; i >= 0; i--) begin
      if (cap_n[i]) begin
        ref_data = data_n[i];
        ref_err  = err_n[i];
      end
    end
    for (int i = 0; i < NUM_DUTS; i++) begin
      mask_n[i] = !cap_n[i] || (err_n[i] != ref_err) || (!PWRITE && (data_n[i] != ref_data));
    end
    fail_idx = '0;
    for (int i = NUM_DUTS - 1; i >= 0; i--) begin
      if (mask_n[i]) fail_idx = IDX_W'(i);
    end
  end

  // Output and bookkeeping next-state; a new mismatch takes priority over clear.
  always_comb begin
    pready_d   = go_cmp;
    prdata_d   = (go_cmp && !PWRITE) ? ref_data : '0;
    pslverr_d  = go_cmp & ref_err;
    mismatch_d = go_cmp & (|mask_n);
    mask_d     = go_cmp ? mask_n : mask_q;
    timeout_d  = tmo;
    perr_d     = abort;
    sticky_d   = sticky_q;
    count_d    = count_q;
    first_d    = first_q;
    if (mismatch_d) begin
      sticky_d = 1'b1;
      if (clear)
        count_d = CNT_WIDTH'(1);
      else if (count_q != '1)
        count_d = count_q + CNT_WIDTH'(1);
      if (!sticky_q || clear)
        first_d = fail_idx;
    end else if (clear) begin
      sticky_d = 1'b0;
      count_d  = '0;
      first_d  = '0;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cap_q      <= '0;
      err_q      <= '0;
      skew_q     <= '0;
      pready_q   <= 1'b0;
      prdata_q   <= '0;
      pslverr_q  <= 1'b0;
      mismatch_q <= 1'b0;
      mask_q     <= '0;
      sticky_q   <= 1'b0;
      count_q    <= '0;
      timeout_q  <= 1'b0;
      perr_q     <= 1'b0;
      first_q    <= '0;
      for (int i = 0; i < NUM_DUTS; i++) data_q[i] <= '0;
    end else begin
      cap_q      <= cap_d;
      err_q      <= err_n;
      skew_q     <= skew_d;
      pready_q   <= pready_d;
      prdata_q   <= prdata_d;
      pslverr_q  <= pslverr_d;
      mismatch_q <= mismatch_d;
      mask_q     <= mask_d;
      sticky_q   <= sticky_d;
      count_q    <= count_d;
      timeout_q  <= timeout_d;
      perr_q     <= perr_d;
      first_q    <= first_d;
      for (int i = 0; i < NUM_DUTS; i++) data_q[i] <= data_n[i];
    end
  end

  assign pready_out      = pready_q;
  assign prdata_out      = prdata_q;
  assign pslverr_out     = pslverr_q;
  assign mismatch        = mismatch_q;
  assign mismatch_mask   = mask_q;
  assign mismatch_sticky = sticky_q;
  assign mismatch_count  = count_q;
  assign timeout         = timeout_q;
  assign protocol_err    = perr_q;
  assign first_idx       = first_q;

endmodule

// File: tb/tb_apb_lockstep_checker.sv
// Directed bench for apb_lockstep_checker: three instances (2-way, 3-way, 2-way with a
// 2-bit counter) share the master signals; each has its own replica inputs.
module tb_apb_lockstep_checker;

  logic PCLK = 1'b0;
  logic PRESETn, PSEL, PENABLE, PWRITE, clear;

  logic [1:0]  a_pready, a_pslverr, a_mask;
  logic [63:0] a_prdata;
  logic [31:0] a_prdata_out;
  logic        a_pready_out, a_pslverr_out, a_mismatch, a_sticky, a_timeout, a_perr;
  logic [15:0] a_count;
  logic [0:0]  a_first;

  logic [2:0]  b_pready, b_pslverr, b_mask;
  logic [95:0] b_prdata;
  logic [31:0] b_prdata_out;
  logic        b_pready_out, b_pslverr_out, b_mismatch, b_sticky, b_timeout, b_perr;
  logic [15:0] b_count;
  logic [1:0]  b_first;

  logic [1:0]  c_pready, c_pslverr, c_mask;
  logic [63:0] c_prdata;
  logic [31:0] c_prdata_out;
  logic        c_pready_out, c_pslverr_out, c_mismatch, c_sticky, c_timeout, c_perr;
  logic [1:0]  c_count;
  logic [0:0]  c_first;

  int checks = 0;
  int failures = 0;

  always #5 PCLK = ~PCLK;

  apb_lockstep_checker #(.NUM_DUTS(2), .DATA_WIDTH(32), .MAX_SKEW(4), .CNT_WIDTH(16)) u2 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .dut_pready(a_pready), .dut_prdata(a_prdata), .dut_pslverr(a_pslverr), .clear(clear),
    .pready_out(a_pready_out), .prdata_out(a_prdata_out), .pslverr_out(a_pslverr_out),
    .mismatch(a_mismatch), .mismatch_mask(a_mask), .mismatch_sticky(a_sticky),
    .mismatch_count(a_count), .timeout(a_timeout), .protocol_err(a_perr), .first_idx(a_first));

  apb_lockstep_checker #(.NUM_DUTS(3), .DATA_WIDTH(32), .MAX_SKEW(4), .CNT_WIDTH(16)) u3 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .dut_pready(b_pready), .dut_prdata(b_prdata), .dut_pslverr(b_pslverr), .clear(clear),
    .pready_out(b_pready_out), .prdata_out(b_prdata_out), .pslverr_out(b_pslverr_out),
    .mismatch(b_mismatch), .mismatch_mask(b_mask), .mismatch_sticky(b_sticky),
    .mismatch_count(b_count), .timeout(b_timeout), .protocol_err(b_perr), .first_idx(b_first));

  apb_lockstep_checker #(.NUM_DUTS(2), .DATA_WIDTH(32), .MAX_SKEW(4), .CNT_WIDTH(2)) uc (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .dut_pready(c_pready), .dut_prdata(c_prdata), .dut_pslverr(c_pslverr), .clear(clear),
    .pready_out(c_pready_out), .prdata_out(c_prdata_out), .pslverr_out(c_pslverr_out),
    .mismatch(c_mismatch), .mismatch_mask(c_mask), .mismatch_sticky(c_sticky),
    .mismatch_count(c_count), .timeout(c_timeout), .protocol_err(c_perr), .first_idx(c_first));

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic setup_phase(input logic wr);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr;
    tick();
    PENABLE = 1'b1;
  endtask

  task automatic end_xfer();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    a_pready = '0; b_pready = '0; c_pready = '0;
    tick();
  endtask

  task automatic test_reset();
    PRESETn = 1'b0; PSEL = 0; PENABLE = 0; PWRITE = 0; clear = 0;
    a_pready = '0; a_pslverr = '0; a_prdata = '0;
    b_pready = '0; b_pslverr = '0; b_prdata = '0;
    c_pready = '0; c_pslverr = '0; c_prdata = '0;
    tick(); tick();
    if ({a_pready_out, a_prdata_out, a_pslverr_out, a_mismatch, a_mask, a_sticky, a_count,
         a_timeout, a_perr, a_first} !== '0) begin
      failures++; $display("FAIL reset_u2 outputs not all zero");
    end
    checks++;
    if ({b_pready_out, b_mismatch, b_mask, b_sticky, b_count, b_timeout, b_perr, b_first} !== '0) begin
      failures++; $display("FAIL reset_u3 outputs not all zero");
    end
    checks++;
    PRESETn = 1'b1;
    tick();
  endtask

  task automatic test_basic_read();
    setup_phase(1'b0);
    a_pready = 2'b11; a_prdata = {32'hDEADBEEF, 32'hDEADBEEF};
    tick();
    if (a_pready_out !== 1'b1) begin failures++; $display("FAIL basic_pready got=%0b exp=1", a_pready_out); end
    checks++;
    if (a_prdata_out !== 32'hDEADBEEF) begin failures++; $display("FAIL basic_prdata got=%h exp=deadbeef", a_prdata_out); end
    checks++;
    if (a_mismatch !== 1'b0 || a_count !== 16'd0) begin
      failures++; $display("FAIL basic_nomis got mis=%0b cnt=%0d exp 0/0", a_mismatch, a_count);
    end
    checks++;
    end_xfer();
    if (a_pready_out !== 1'b0) begin failures++; $display("FAIL basic_pready_drop got=%0b exp=0", a_pready_out); end
    checks++;
  endtask

  task automatic test_skew();
    setup_phase(1'b0);
    a_pready = 2'b01; a_prdata = {32'h12345678, 32'h12345678};
    tick(); tick(); tick();
    if (a_pready_out !== 1'b0) begin failures++; $display("FAIL skew_wait got=%0b exp=0", a_pready_out); end
    checks++;
    a_pready = 2'b11;
    tick();
    if (a_pready_out !== 1'b1 || a_timeout !== 1'b0 || a_mismatch !== 1'b0) begin
      failures++; $display("FAIL skew_done got rdy=%0b to=%0b mis=%0b exp 1/0/0", a_pready_out, a_timeout, a_mismatch);
    end
    checks++;
    if (a_prdata_out !== 32'h12345678) begin failures++; $display("FAIL skew_prdata got=%h exp=12345678", a_prdata_out); end
    checks++;
    end_xfer();
  endtask

  task automatic test_timeout();
    setup_phase(1'b0);
    a_pready = 2'b01; a_prdata = {32'h0, 32'h55};
    tick(); tick(); tick(); tick();
    if (a_timeout !== 1'b0 || a_pready_out !== 1'b0) begin
      failures++; $display("FAIL tmo_early got to=%0b rdy=%0b exp 0/0", a_timeout, a_pready_out);
    end
    checks++;
    tick();
    if (a_timeout !== 1'b1 || a_pready_out !== 1'b1) begin
      failures++; $display("FAIL tmo_fire got to=%0b rdy=%0b exp 1/1", a_timeout, a_pready_out);
    end
    checks++;
    if (a_mask !== 2'b10 || a_mismatch !== 1'b1) begin
      failures++; $display("FAIL tmo_mask got mask=%b mis=%0b exp 10/1", a_mask, a_mismatch);
    end
    checks++;
    if (a_count !== 16'd1 || a_first !== 1'b1 || a_sticky !== 1'b1) begin
      failures++; $display("FAIL tmo_count got cnt=%0d first=%0d sticky=%0b exp 1/1/1", a_count, a_first, a_sticky);
    end
    checks++;
    end_xfer();
    if (a_timeout !== 1'b0) begin failures++; $display("FAIL tmo_pulse got=%0b exp=0", a_timeout); end
    checks++;
  endtask

  task automatic test_write();
    setup_phase(1'b1);
    a_pready = 2'b11; a_pslverr = 2'b10; a_prdata = {32'hAAAA0000, 32'h0000BBBB};
    tick();
    if (a_mask !== 2'b10 || a_mismatch !== 1'b1) begin
      failures++; $display("FAIL wr_err_mask got mask=%b mis=%0b exp 10/1", a_mask, a_mismatch);
    end
    checks++;
    if (a_prdata_out !== 32'h0 || a_pslverr_out !== 1'b0 || a_count !== 16'd2) begin
      failures++; $display("FAIL wr_err_out got d=%h e=%0b cnt=%0d exp 0/0/2", a_prdata_out, a_pslverr_out, a_count);
    end
    checks++;
    end_xfer();
    setup_phase(1'b1);
    a_pready = 2'b11; a_pslverr = 2'b11; a_prdata = {32'h11111111, 32'h22222222};
    tick();
    if (a_mismatch !== 1'b0 || a_mask !== 2'b00 || a_count !== 16'd2 || a_pslverr_out !== 1'b1) begin
      failures++; $display("FAIL wr_data_ignored got mis=%0b mask=%b cnt=%0d err=%0b exp 0/00/2/1",
                           a_mismatch, a_mask, a_count, a_pslverr_out);
    end
    checks++;
    a_pslverr = 2'b00;
    end_xfer();
  endtask

  task automatic test_protocol_abort();
    setup_phase(1'b0);
    a_pready = 2'b01;
    tick();
    end_xfer();
    if (a_perr !== 1'b1 || a_pready_out !== 1'b0) begin
      failures++; $display("FAIL abort_pulse got perr=%0b rdy=%0b exp 1/0", a_perr, a_pready_out);
    end
    checks++;
    if (a_count !== 16'd2) begin failures++; $display("FAIL abort_count got=%0d exp=2", a_count); end
    checks++;
    tick();
    if (a_perr !== 1'b0) begin failures++; $display("FAIL abort_once got=%0b exp=0", a_perr); end
    checks++;
  endtask

  task automatic test_three_way();
    setup_phase(1'b0);
    b_pready = 3'b111; b_prdata = {32'h00000001, 32'h0, 32'h0};
    tick();
    if (b_mismatch !== 1'b1 || b_mask !== 3'b100) begin
      failures++; $display("FAIL n3_mask got mis=%0b mask=%b exp 1/100", b_mismatch, b_mask);
    end
    checks++;
    if (b_sticky !== 1'b1 || b_count !== 16'd1 || b_first !== 2'd2) begin
      failures++; $display("FAIL n3_track got sticky=%0b cnt=%0d first=%0d exp 1/1/2", b_sticky, b_count, b_first);
    end
    checks++;
    if (b_prdata_out !== 32'h0) begin failures++; $display("FAIL n3_ref got=%h exp=0", b_prdata_out); end
    checks++;
    end_xfer();
    if (b_mismatch !== 1'b0 || b_mask !== 3'b100 || b_sticky !== 1'b1) begin
      failures++; $display("FAIL n3_hold got mis=%0b mask=%b sticky=%0b exp 0/100/1", b_mismatch, b_mask, b_sticky);
    end
    checks++;
  endtask

  task automatic test_saturate_clear();
    logic [1:0] exp_cnt;
    for (int k = 1; k <= 5; k++) begin
      setup_phase(1'b0);
      c_pready = 2'b11; c_prdata = {32'h000000A5, 32'h0};
      tick();
      exp_cnt = (k > 3) ? 2'd3 : 2'(k);
      if (c_count !== exp_cnt) begin
        failures++; $display("FAIL sat_count_%0d got=%0d exp=%0d", k, c_count, exp_cnt);
      end
      checks++;
      end_xfer();
    end
    setup_phase(1'b0);
    c_pready = 2'b11; c_prdata = {32'h000000A5, 32'h0}; clear = 1'b1;
    tick();
    clear = 1'b0;
    if (c_count !== 2'd1 || c_sticky !== 1'b1 || c_first !== 1'b1) begin
      failures++; $display("FAIL clr_vs_mis got cnt=%0d sticky=%0b first=%0d exp 1/1/1", c_count, c_sticky, c_first);
    end
    checks++;
    end_xfer();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    if (c_count !== 2'd0 || c_sticky !== 1'b0) begin
      failures++; $display("FAIL clr_alone got cnt=%0d sticky=%0b exp 0/0", c_count, c_sticky);
    end
    checks++;
  endtask

  task automatic test_reset_mid_transfer();
    setup_phase(1'b0);
    a_pready = 2'b01;
    tick();
    #1 PRESETn = 1'b0;
    #1;
    if ({a_pready_out, a_prdata_out, a_pslverr_out, a_mismatch, a_mask, a_sticky, a_count,
         a_timeout, a_perr, a_first} !== '0) begin
      failures++; $display("FAIL rst_mid outputs not zero cnt=%0d sticky=%0b", a_count, a_sticky);
    end
    checks++;
    PSEL = 0; PENABLE = 0; a_pready = '0;
    tick();
    PRESETn = 1'b1;
    tick();
    if (a_perr !== 1'b0 || a_pready_out !== 1'b0) begin
      failures++; $display("FAIL rst_mid_nopulse got perr=%0b rdy=%0b exp 0/0", a_perr, a_pready_out);
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_skew();
    test_timeout();
    test_write();
    test_protocol_abort();
    test_three_way();
    test_saturate_clear();
    test_reset_mid_transfer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_lockstep_checker.md
Name: apb_lockstep_checker

Overview:
Synthesisable N-way lockstep checker for replicated APB completers. It generalises the two-DUT PRDATA equivalence check to NUM_DUTS replicas, and tolerates per-replica wait-state skew up to MAX_SKEW cycles. A single master broadcasts PSEL/PENABLE/PWRITE to all replicas. The checker collects each replica's response, returns one merged response to the master, and flags, counts and localises any divergence.

Parameters:
NUM_DUTS, 2, number of replicated completers (2..8)
DATA_WIDTH, 32, PRDATA width
MAX_SKEW, 4, max cycles between first and last replica PREADY within one transfer (1..15)
CNT_WIDTH, 16, width of saturating mismatch counter

Ports:
PCLK  in  1  clock, all logic on posedge
PRESETn  in  1  asynchronous active-low reset
PSEL  in  1  broadcast select from master
PENABLE  in  1  broadcast enable from master
PWRITE  in  1  broadcast direction from master
dut_pready  in  NUM_DUTS  per-replica PREADY
dut_prdata  in  NUM_DUTS*DATA_WIDTH  per-replica PRDATA, replica i at bits [i*DATA_WIDTH +: DATA_WIDTH]
dut_pslverr  in  NUM_DUTS  per-replica PSLVERR
clear  in  1  synchronous clear of sticky flag, counter and first-mismatch capture
pready_out  out  1  merged PREADY to master
prdata_out  out  DATA_WIDTH  merged PRDATA (reference replica)
pslverr_out  out  1  merged PSLVERR (reference replica)
mismatch  out  1  one-cycle pulse: current transfer diverged
mismatch_mask  out  NUM_DUTS  replicas differing from reference in current transfer
mismatch_sticky  out  1  set on any mismatch, held until clear
mismatch_count  out  CNT_WIDTH  saturating count of mismatching transfers
timeout  out  1  one-cycle pulse: skew exceeded MAX_SKEW
protocol_err  out  1  one-cycle pulse: PSEL or PENABLE dropped before merged completion
first_idx  out  $clog2(NUM_DUTS) (min 1)  lowest failing replica index of first mismatch since clear/reset

Behaviour:
- Reset (PRESETn=0, async): FSM to IDLE; all outputs, captured-response registers, capture flags and skew counter to 0.
- States: IDLE, COLLECT, COMPARE.
- Access phase = PSEL && PENABLE.
- Capture rule: at each posedge in IDLE/COLLECT during an access phase, for every replica i not yet captured with dut_pready[i]=1:
  - store its prdata/pslverr and set captured[i];
  - each replica is captured at most once per transfer; later PREADY ignored.
- IDLE:
  - access phase and all replicas captured (including this edge) -> COMPARE;
  - access phase otherwise -> COLLECT.
- COLLECT:
  - skew counter starts at 0 on the edge the first capture occurs and increments every following edge while not all captured;
  - all captured -> COMPARE;
  - skew counter reaches MAX_SKEW with some uncaptured -> timeout pulse, uncaptured replicas marked failing, -> COMPARE;
  - zero captures: wait indefinitely.
- Abort: access phase deasserted in COLLECT -> protocol_err pulse, -> IDLE, no compare, counters unchanged.
- COMPARE: lasts exactly one cycle, then -> IDLE. Registered on entry:
  - reference = lowest-index captured replica; if none captured, mismatch_mask = all ones;
  - read (PWRITE=0): replica fails if missing, or prdata or pslverr differs from reference;
  - write (PWRITE=1): replica fails if missing or pslverr differs; prdata ignored;
  - pready_out=1, prdata_out/pslverr_out = reference values (prdata_out=0 on writes);
  - mismatch = |mismatch_mask.
- Outside COMPARE: pready_out, mismatch and timeout are 0; mismatch_mask holds its last value.
- Latency: pready_out rises 1 cycle after the edge capturing the last replica. Master access phase = max replica wait + 1.
- Sticky/counter/first capture:
  - mismatch_sticky set on mismatch;
  - mismatch_count increments on mismatch and saturates at 2^CNT_WIDTH-1;
  - first_idx loaded only while sticky is 0.
- clear on the same edge as a new mismatch: the mismatch wins (count=1, sticky=1, first_idx from the new event). clear alone zeroes all three.
- Reset mid-transfer: async abort, no pulses generated.

Test Plan:
- NUM_DUTS=2, read, both PREADY same cycle, PRDATA=0xDEADBEEF both -> pready_out 1 cycle later, prdata_out=0xDEADBEEF, mismatch=0, count=0.
- NUM_DUTS=3, read, replica 2 returns 0x0000_0001 vs 0x0 -> mismatch pulse, mismatch_mask=3'b100, sticky=1, count=1, first_idx=2.
- NUM_DUTS=2, MAX_SKEW=4, replica 1 PREADY 3 cycles after replica 0 with equal data -> no timeout, pready_out 1 cycle after replica 1. With replica 1 never ready -> timeout after 4 cycles, mask=2'b10.
- Write, PSLVERR 0 vs 1, PRDATA differing -> mismatch_mask=2'b10. Write with equal PSLVERR but PRDATA differing -> mismatch=0.
- PSEL dropped in COLLECT -> protocol_err pulse, return to IDLE, count unchanged. PRESETn low mid-COLLECT -> all outputs 0 immediately.
- CNT_WIDTH=2, five mismatching reads -> count saturates at 3. clear coincident with 6th mismatch -> count=1, sticky=1.
